// File: rtl/pc_register_ras.sv
// Program-counter register with sequencing ops, stall control and a circular
// return-address stack with sticky overflow/underflow status.
module pc_register_ras #(
  parameter int unsigned       WIDTH        = 20,
  parameter int unsigned       STEP         = 1,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
  parameter int unsigned       RAS_DEPTH    = 4,
  localparam int unsigned      CW           = $clog2(RAS_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] offset,
  input  logic             err_clr,
  output logic [WIDTH-1:0] PCOut,
  output logic [CW-1:0]    ras_count,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_overflow,
  output logic             ras_underflow
);

  localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  typedef enum logic [2:0] {
    OpNext   = 3'd0,
    OpJump   = 3'd1,
    OpBranch = 3'd2,
    OpCall   = 3'd3,
    OpRet    = 3'd4
  } op_e;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    wp_q, wp_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             push;
  logic [WIDTH-1:0] ret_addr;
  logic [PW-1:0]    wp_inc, wp_dec;
  logic             full;

  logic [WIDTH-1:0] stack_q [RAS_DEPTH];

  assign ret_addr = pc_q + WIDTH'(STEP);
  assign full     = (cnt_q == CW'(RAS_DEPTH));

  // wp points at the next free slot; when full that slot holds the oldest entry,
  // so a push there is exactly the circular overwrite.
  assign wp_inc = (wp_q == PW'(RAS_DEPTH - 1)) ? '0 : wp_q + PW'(1);
  assign wp_dec = (wp_q == '0) ? PW'(RAS_DEPTH - 1) : wp_q - PW'(1);

  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    wp_d  = wp_q;
    ovf_d = err_clr ? 1'b0 : ovf_q;
    unf_d = err_clr ? 1'b0 : unf_q;
    push  = 1'b0;
    if (en) begin
      case (op)
        OpNext:   pc_d = ret_addr;
        OpJump:   pc_d = target;
        OpBranch: pc_d = pc_q + offset;
        OpCall: begin
          push = 1'b1;
          pc_d = target;
          wp_d = wp_inc;
          if (full) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        OpRet: begin
          if (cnt_q != '0) begin
            pc_d  = stack_q[wp_dec];
            wp_d  = wp_dec;
            cnt_d = cnt_q - CW'(1);
          end else begin
            unf_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q  <= RESET_VECTOR;
      cnt_q <= '0;
      wp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      wp_q  <= wp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Entry contents need no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      stack_q[wp_q] <= ret_addr;
    end
  end

  assign PCOut         = pc_q;
  assign ras_count     = cnt_q;
  assign ras_empty     = (cnt_q == '0);
  assign ras_full      = full;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_register_ras.sv
// Bench for pc_register_ras: directed vector table followed by random traffic
// checked against a queue-based reference model.
module tb_pc_register_ras;

  localparam int unsigned      W     = 20;
  localparam int unsigned      D     = 4;
  localparam int unsigned      CW    = $clog2(D + 1);
  localparam logic [W-1:0]     RV    = 20'h00100;

  localparam logic [2:0] NX = 3'd0, JP = 3'd1, BR = 3'd2, CL = 3'd3, RT = 3'd4,
                         H5 = 3'd5, H6 = 3'd6, H7 = 3'd7;

  logic          clk = 1'b0;
  logic          reset, en, err_clr;
  logic [2:0]    op;
  logic [W-1:0]  target, offset;
  logic [W-1:0]  pc_out;
  logic [CW-1:0] ras_count;
  logic          ras_empty, ras_full, ras_overflow, ras_underflow;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_register_ras #(
    .WIDTH(W), .STEP(1), .RESET_VECTOR(RV), .RAS_DEPTH(D)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .op(op), .target(target), .offset(offset),
    .err_clr(err_clr), .PCOut(pc_out), .ras_count(ras_count), .ras_empty(ras_empty),
    .ras_full(ras_full), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  // Reference model: PC as a number, RAS as a bounded queue (back = newest).
  logic [W-1:0] m_pc;
  logic [W-1:0] m_ras[$];
  logic         m_ovf, m_unf;

  task automatic model_step(input logic r, input logic e, input logic [2:0] o,
                            input logic [W-1:0] t, input logic [W-1:0] off,
                            input logic c);
    logic nov, nun;
    logic [W-1:0] ra;
    if (!r) begin
      m_pc = RV;
      m_ras.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      nov = c ? 1'b0 : m_ovf;
      nun = c ? 1'b0 : m_unf;
      ra  = m_pc + 20'd1;
      if (e) begin
        if (o == NX) m_pc = ra;
        else if (o == JP) m_pc = t;
        else if (o == BR) m_pc = m_pc + off;
        else if (o == CL) begin
          m_ras.push_back(ra);
          if (m_ras.size() > D) begin
            void'(m_ras.pop_front());
            nov = 1'b1;
          end
          m_pc = t;
        end else if (o == RT) begin
          if (m_ras.size() > 0) m_pc = m_ras.pop_back();
          else nun = 1'b1;
        end
      end
      m_ovf = nov;
      m_unf = nun;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic r, input logic e, input logic [2:0] o,
                       input logic [W-1:0] t, input logic [W-1:0] off, input logic c);
    reset = r; en = e; op = o; target = t; offset = off; err_clr = c;
    @(posedge clk);
    model_step(r, e, o, t, off, c);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [W-1:0] pc, input int cnt,
                           input logic ov, input logic un);
    chk({tag, ".pc"}, 32'(pc_out), 32'(pc));
    chk({tag, ".count"}, 32'(ras_count), 32'(cnt));
    chk({tag, ".empty"}, 32'(ras_empty), 32'(cnt == 0));
    chk({tag, ".full"}, 32'(ras_full), 32'(cnt == D));
    chk({tag, ".ovf"}, 32'(ras_overflow), 32'(ov));
    chk({tag, ".unf"}, 32'(ras_underflow), 32'(un));
  endtask

  typedef struct {
    logic         r, e;
    logic [2:0]   o;
    logic [W-1:0] t, off;
    logic         c;
    logic [W-1:0] pc;
    int           cnt;
    logic         ov, un;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t v(logic r, logic e, logic [2:0] o, logic [W-1:0] t,
                             logic [W-1:0] off, logic c, logic [W-1:0] pc, int cnt,
                             logic ov, logic un);
    vec_t x;
    x.r = r; x.e = e; x.o = o; x.t = t; x.off = off; x.c = c;
    x.pc = pc; x.cnt = cnt; x.ov = ov; x.un = un;
    return x;
  endfunction

  initial begin
    //             rst en op  target    offset    clr  pc        cnt ov un
    vt.push_back(v(0, 1, CL, 20'h00555, 20'h0, 0, 20'h00100, 0, 0, 0));
    vt.push_back(v(0, 1, CL, 20'h00555, 20'h0, 0, 20'h00100, 0, 0, 0));
    vt.push_back(v(1, 1, NX, 20'h0, 20'h0, 0, 20'h00101, 0, 0, 0));
    vt.push_back(v(1, 1, NX, 20'h0, 20'h0, 0, 20'h00102, 0, 0, 0));
    vt.push_back(v(1, 1, NX, 20'h0, 20'h0, 0, 20'h00103, 0, 0, 0));
    vt.push_back(v(1, 1, JP, 20'hFFFFF, 20'h0, 0, 20'hFFFFF, 0, 0, 0));
    vt.push_back(v(1, 1, NX, 20'h0, 20'h0, 0, 20'h00000, 0, 0, 0));
    vt.push_back(v(1, 1, BR, 20'h0, 20'hFFFFE, 0, 20'hFFFFE, 0, 0, 0));
    vt.push_back(v(1, 1, BR, 20'h0, 20'h00010, 0, 20'h0000E, 0, 0, 0));
    vt.push_back(v(1, 1, JP, 20'h00200, 20'h0, 0, 20'h00200, 0, 0, 0));
    vt.push_back(v(1, 1, CL, 20'h01000, 20'h0, 0, 20'h01000, 1, 0, 0));
    vt.push_back(v(1, 1, CL, 20'h02000, 20'h0, 0, 20'h02000, 2, 0, 0));
    vt.push_back(v(1, 1, RT, 20'h0, 20'h0, 0, 20'h01001, 1, 0, 0));
    vt.push_back(v(1, 1, RT, 20'h0, 20'h0, 0, 20'h00201, 0, 0, 0));
    vt.push_back(v(1, 1, JP, 20'h00010, 20'h0, 0, 20'h00010, 0, 0, 0));
    vt.push_back(v(1, 1, CL, 20'h00020, 20'h0, 0, 20'h00020, 1, 0, 0));
    vt.push_back(v(1, 1, CL, 20'h00030, 20'h0, 0, 20'h00030, 2, 0, 0));
    vt.push_back(v(1, 1, CL, 20'h00040, 20'h0, 0, 20'h00040, 3, 0, 0));
    vt.push_back(v(1, 1, CL, 20'h00050, 20'h0, 0, 20'h00050, 4, 0, 0));
    vt.push_back(v(1, 1, CL, 20'h00060, 20'h0, 0, 20'h00060, 4, 1, 0));
    vt.push_back(v(1, 1, RT, 20'h0, 20'h0, 0, 20'h00051, 3, 1, 0));
    vt.push_back(v(1, 1, RT, 20'h0, 20'h0, 0, 20'h00041, 2, 1, 0));
    vt.push_back(v(1, 1, RT, 20'h0, 20'h0, 0, 20'h00031, 1, 1, 0));
    vt.push_back(v(1, 1, RT, 20'h0, 20'h0, 0, 20'h00021, 0, 1, 0));
    vt.push_back(v(1, 1, RT, 20'h0, 20'h0, 0, 20'h00021, 0, 1, 1));
    vt.push_back(v(1, 0, JP, 20'hABCDE, 20'h0, 0, 20'h00021, 0, 1, 1));
    vt.push_back(v(1, 0, JP, 20'hABCDE, 20'h0, 0, 20'h00021, 0, 1, 1));
    vt.push_back(v(1, 0, JP, 20'hABCDE, 20'h0, 0, 20'h00021, 0, 1, 1));
    vt.push_back(v(1, 0, JP, 20'hABCDE, 20'h0, 1, 20'h00021, 0, 0, 0));
    vt.push_back(v(1, 1, RT, 20'h0, 20'h0, 1, 20'h00021, 0, 0, 1));
    vt.push_back(v(1, 1, H7, 20'h12345, 20'h0, 1, 20'h00021, 0, 0, 0));
    vt.push_back(v(1, 1, CL, 20'h00300, 20'h0, 0, 20'h00300, 1, 0, 0));
    vt.push_back(v(1, 1, CL, 20'h00400, 20'h0, 0, 20'h00400, 2, 0, 0));
    vt.push_back(v(0, 1, RT, 20'h0, 20'h0, 0, 20'h00100, 0, 0, 0));
    vt.push_back(v(1, 1, RT, 20'h0, 20'h0, 0, 20'h00100, 0, 0, 1));
    vt.push_back(v(1, 1, H5, 20'h54321, 20'h7, 0, 20'h00100, 0, 0, 1));
    vt.push_back(v(1, 1, H6, 20'h54321, 20'h7, 0, 20'h00100, 0, 0, 1));

    m_pc = RV; m_ovf = 1'b0; m_unf = 1'b0;
    for (int i = 0; i < vt.size(); i++) begin
      apply(vt[i].r, vt[i].e, vt[i].o, vt[i].t, vt[i].off, vt[i].c);
      chk_state($sformatf("vec%0d", i), vt[i].pc, vt[i].cnt, vt[i].ov, vt[i].un);
    end

    // Random traffic; CALL/RET weighted up so the stack fills and drains.
    for (int i = 0; i < 2000; i++) begin
      logic r, e, c;
      logic [2:0] o;
      int sel;
      r   = ($urandom_range(99) >= 2);
      e   = ($urandom_range(99) < 85);
      c   = ($urandom_range(99) < 10);
      sel = $urandom_range(9);
      o   = (sel < 3) ? CL : (sel < 6) ? RT : 3'($urandom_range(7));
      apply(r, e, o, 20'($urandom), 20'($urandom), c);
      chk_state($sformatf("rnd%0d", i), m_pc, m_ras.size(), m_ovf, m_unf);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_register_ras.md
Name: pc_register_ras

Overview:
- Parametrised program-counter register. Successor to the fixed 20-bit PC register.
- Adds the following on top of plain load/hold:
  - sequencing ops: increment, absolute jump, PC-relative branch, call, return
  - stall control
  - an internal return-address stack (RAS) with overflow/underflow status
- Sits between the next-PC select logic and instruction fetch. PCOut drives the fetch address.

Parameters:
- WIDTH, 20, PC width in bits (≥4).
- STEP, 1, increment added for NEXT and for the CALL return address (unsigned, < 2^WIDTH).
- RESET_VECTOR, 0, PC value after reset (WIDTH bits).
- RAS_DEPTH, 4, return-address stack entries (≥1; need not be a power of two).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  reset. Synchronous. Active-low: 0 = reset on the next rising clk edge.
- en  input  1  advance enable. 0 = stall: all state holds and op is ignored.
- op  input  3  operation, sampled when en=1:
  - 000 NEXT
  - 001 JUMP
  - 010 BRANCH
  - 011 CALL
  - 100 RET
  - 101–111 HOLD
- target  input  WIDTH  absolute destination for JUMP and CALL.
- offset  input  WIDTH  two's-complement signed displacement for BRANCH.
- err_clr  input  1  clears the sticky error flags.
- PCOut  output  WIDTH  current PC (registered).
- ras_count  output  clog2(RAS_DEPTH+1)  number of valid RAS entries.
- ras_empty  output  1  ras_count==0.
- ras_full  output  1  ras_count==RAS_DEPTH.
- ras_overflow  output  1  sticky: a CALL was made while the RAS was full.
- ras_underflow  output  1  sticky: a RET was made while the RAS was empty.

Behaviour:
- All state updates on rising clk only. No combinational path from any input to any output.
- Reset (reset=0 at an edge), highest priority, overrides en/op/err_clr:
  - PCOut=RESET_VECTOR
  - ras_count=0
  - ras_overflow=0, ras_underflow=0
  - RAS entry contents don't-care
  - ras_empty=1, ras_full=0 (or 1 only if RAS_DEPTH were 0, which is illegal)
- Latency: op sampled at edge N is reflected on PCOut after edge N (one cycle).
- en=0: PCOut, RAS and its pointers hold. err_clr still acts.
- Op effects when en=1 (all arithmetic modulo 2^WIDTH; wrap-around is silent, no flag):
  - NEXT: PC <= PC+STEP.
  - JUMP: PC <= target.
  - BRANCH: PC <= PC+offset, offset sign-extended within WIDTH. Example: offset=all-ones means PC-1.
  - CALL:
    - push PC+STEP, then PC <= target.
    - If full: overwrite the oldest entry (circular), ras_count stays RAS_DEPTH, and ras_overflow <= 1.
    - The newest entry is always the pushed address.
  - RET:
    - If ras_count>0: PC <= top entry and pop (ras_count-1).
    - If empty: PC holds and ras_underflow <= 1.
  - HOLD codes: PC and RAS unchanged.
- RAS is LIFO: after overflow, successive RETs return the RAS_DEPTH most recent addresses, newest first.
- err_clr=1: clears both sticky flags. If a new error is raised in the same cycle, set wins (the flag stays 1).
- Reset mid-sequence (e.g. inside nested calls) discards all RAS contents. The next RET underflows.

Test Plan (WIDTH=20, STEP=1, RESET_VECTOR=0x00100, RAS_DEPTH=4):
- Hold reset=0 for 2 cycles with op=CALL, en=1 → PCOut=0x00100, ras_count=0, ras_empty=1, flags 0. Then 3×NEXT → 0x00101, 0x00102, 0x00103.
- PC=0xFFFFF, NEXT → 0x00000. Then BRANCH offset=0xFFFFE → 0xFFFFE. Then BRANCH offset=0x00010 → 0x0000E.
- From PC=0x00200: CALL target=0x01000 → PC=0x01000, count=1. CALL 0x02000 → count=2. RET → PC=0x01001. RET → PC=0x00201, empty.
- Overflow: 5×CALL from PCs 0x10, 0x20, 0x30, 0x40, 0x50 (targets 0x20, 0x30, 0x40, 0x50, 0x60) → ras_full=1 and ras_overflow=1 after the 5th. 4×RET → 0x51, 0x41, 0x31, 0x21. 5th RET → PC holds at 0x21, ras_underflow=1.
- en=0 for 3 cycles with op=JUMP target=0xABCDE → PCOut unchanged. Then err_clr=1 alone clears both flags. err_clr=1 together with RET on an empty RAS → ras_underflow=1.
- Reset=0 asserted in the cycle after two CALLs → PC=0x00100, count=0. The following RET → PC holds, ras_underflow=1.
